// File: rtl/alu_pkg.sv
// Shared ALU types and constants for the op sequencer: datapath widths,
// opcode encodings and the issue FSM state enum.
package alu_pkg;

   localparam int ALU_DATA_W = 4;
   localparam int ALU_SEL_W  = 3;

   localparam logic [2:0] OP_ADD        = 3'b000;
   localparam logic [2:0] OP_SUB        = 3'b001;
   localparam logic [2:0] OP_AND        = 3'b010;
   localparam logic [2:0] OP_OR         = 3'b011;
   localparam logic [2:0] OP_XOR        = 3'b100;
   localparam logic [2:0] OP_LAST_LEGAL = OP_XOR;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2
   } seq_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO for the op sequencer. Full/empty come from
// pointers carrying one extra wrap bit, so all DEPTH entries are usable.
module alu_cmd_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rdata = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop && !empty) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[wr_ptr[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage for the 4-bit combinational ALU: buffers commands, issues them one at
// a time and returns results in order. Define ALU_OP_CHECK_EN to reject illegal opcodes.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W,
   parameter int SEL_W  = ALU_SEL_W,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic [SEL_W-1:0]  cmd_sel,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [SEL_W-1:0]  alu_sel,
   input  logic [DATA_W-1:0] alu_y,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_y,
   output logic [SEL_W-1:0]  res_sel,
   output logic              res_zero,
   output logic [7:0]        issue_cnt
`ifdef ALU_OP_CHECK_EN
  ,output logic              cmd_err
`endif
);

   localparam int CMD_W = 2 * DATA_W + SEL_W;

   seq_state_t        state;
   logic              cmd_fire;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CMD_W-1:0]  fifo_head;
   logic [DATA_W-1:0] head_a;
   logic [DATA_W-1:0] head_b;
   logic [SEL_W-1:0]  head_sel;

   assign cmd_ready = !fifo_full;
   assign cmd_fire  = cmd_valid && cmd_ready;
   assign {head_a, head_b, head_sel} = fifo_head;

`ifdef ALU_OP_CHECK_EN
   logic cmd_legal;

   assign cmd_legal = (cmd_sel <= SEL_W'(OP_LAST_LEGAL));
   assign fifo_push = cmd_fire && cmd_legal;

   // A rejected command still completes its handshake; it is flagged for one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_err <= 1'b0;
      end else begin
         cmd_err <= cmd_fire && !cmd_legal;
      end
   end
`else
   assign fifo_push = cmd_fire;
`endif

   // The pre-edge empty flag gates the pop, so a fresh push waits one cycle.
   assign fifo_pop = !fifo_empty && ((state == IDLE) || ((state == HOLD) && res_ready));

   alu_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .wdata ({cmd_a, cmd_b, cmd_sel}),
      .pop   (fifo_pop),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_sel   <= '0;
         res_valid <= 1'b0;
         res_y     <= '0;
         res_sel   <= '0;
         res_zero  <= 1'b1;
         issue_cnt <= '0;
      end else begin
         if (fifo_pop) begin
            alu_a     <= head_a;
            alu_b     <= head_b;
            alu_sel   <= head_sel;
            issue_cnt <= issue_cnt + 8'd1;
         end
         case (state)
            IDLE: begin
               if (fifo_pop) begin
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               res_y     <= alu_y;
               res_sel   <= alu_sel;
               res_zero  <= (alu_y == '0);
               res_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= fifo_pop ? ISSUE : IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized and directed bench for alu_op_sequencer with a queue-based reference model.
// The ALU behind the sequencer is modelled here from the opcode table.
module tb_alu_op_sequencer;
   import alu_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_a = '0;
   logic [3:0] cmd_b = '0;
   logic [2:0] cmd_sel = '0;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [2:0] alu_sel;
   logic [3:0] alu_y;
   logic       res_valid;
   logic       res_ready = 1'b0;
   logic [3:0] res_y;
   logic [2:0] res_sel;
   logic       res_zero;
   logic [7:0] issue_cnt;
`ifdef ALU_OP_CHECK_EN
   logic       cmd_err;
`endif

   typedef struct {
      logic [3:0] y;
      logic [2:0] sel;
   } exp_t;

   int   checks = 0;
   int   failures = 0;
   exp_t expQ[$];
   int   accepted = 0;
   int   cycle = 0;
   int   lastHsCycle = -100;
   int   lastGap = 0;
   logic prevHold = 1'b0;
   logic [3:0] prevY = '0;
   logic [2:0] prevSel = '0;
   logic errExpect = 1'b0;

   alu_op_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_sel   (cmd_sel),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_sel   (alu_sel),
      .alu_y     (alu_y),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_y     (res_y),
      .res_sel   (res_sel),
      .res_zero  (res_zero),
      .issue_cnt (issue_cnt)
`ifdef ALU_OP_CHECK_EN
     ,.cmd_err   (cmd_err)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] refAlu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
      case (sel)
         OP_ADD:  return 4'(a + b);
         OP_SUB:  return 4'(a - b);
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         default: return 4'd0;
      endcase
   endfunction

   always_comb alu_y = refAlu(alu_a, alu_b, alu_sel);

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
      cmd_valid = v;
      cmd_a     = a;
      cmd_b     = b;
      cmd_sel   = sel;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_res_valid"}, res_valid, 0);
      checkOutput({tag, "_cmd_ready"}, cmd_ready, 1);
      checkOutput({tag, "_alu_a"}, alu_a, 0);
      checkOutput({tag, "_alu_b"}, alu_b, 0);
      checkOutput({tag, "_alu_sel"}, alu_sel, 0);
      checkOutput({tag, "_res_y"}, res_y, 0);
      checkOutput({tag, "_res_sel"}, res_sel, 0);
      checkOutput({tag, "_res_zero"}, res_zero, 1);
      checkOutput({tag, "_issue_cnt"}, issue_cnt, 0);
`ifdef ALU_OP_CHECK_EN
      checkOutput({tag, "_cmd_err"}, cmd_err, 0);
`endif
   endtask

   task automatic resetDut();
      rst_n     = 1'b0;
      res_ready = 1'b0;
      applyStimulus(0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic waitDrain(input int maxCycles);
      int n;
      res_ready = 1'b1;
      n = 0;
      while ((expQ.size() != 0 || res_valid) && n < maxCycles) begin
         nextCycle();
         n++;
      end
      if (n >= maxCycles) begin
         checkOutput("drain_timeout", 0, 1);
      end
   endtask

   // Scoreboard: handshakes are judged on the falling edge from stable pre-edge values.
   always @(negedge clk) begin
      exp_t e;
      cycle++;
      if (!rst_n) begin
         expQ.delete();
         accepted  = 0;
         prevHold  = 1'b0;
         errExpect = 1'b0;
      end else begin
`ifdef ALU_OP_CHECK_EN
         checkOutput("cmd_err", cmd_err, errExpect);
         errExpect = 1'b0;
`endif
         if (prevHold) begin
            checkOutput("hold_valid", res_valid, 1);
            checkOutput("hold_y", res_y, prevY);
            checkOutput("hold_sel", res_sel, prevSel);
         end
         if (cmd_valid && cmd_ready) begin
`ifdef ALU_OP_CHECK_EN
            if (cmd_sel > OP_LAST_LEGAL) begin
               errExpect = 1'b1;
            end else begin
               expQ.push_back('{y: refAlu(cmd_a, cmd_b, cmd_sel), sel: cmd_sel});
               accepted++;
            end
`else
            expQ.push_back('{y: refAlu(cmd_a, cmd_b, cmd_sel), sel: cmd_sel});
            accepted++;
`endif
         end
         if (res_valid && res_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("res_spurious", 1, 0);
            end else begin
               e = expQ.pop_front();
               checkOutput("res_y", res_y, e.y);
               checkOutput("res_sel", res_sel, e.sel);
               checkOutput("res_zero", res_zero, (e.y == 4'd0));
            end
            checkOutput("res_gap_ge2", ((cycle - lastHsCycle) >= 2), 1);
            lastGap     = cycle - lastHsCycle;
            lastHsCycle = cycle;
         end
         prevHold = res_valid && !res_ready;
         prevY    = res_y;
         prevSel  = res_sel;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base;
      int n;
      logic [7:0] cntBefore;

      resetDut();
      checkResetValues("reset");

      // First command: ADD 3+4, result valid two edges after acceptance.
      res_ready = 1'b1;
      applyStimulus(1, 4'd3, 4'd4, OP_ADD);
      nextCycle();
      applyStimulus(0, 0, 0, 0);
      checkOutput("lat_e0_valid", res_valid, 0);
      nextCycle();
      checkOutput("lat_e1_valid", res_valid, 0);
      checkOutput("lat_e1_alu_a", alu_a, 3);
      checkOutput("lat_e1_alu_b", alu_b, 4);
      checkOutput("lat_e1_issue_cnt", issue_cnt, 1);
      nextCycle();
      checkOutput("lat_e2_valid", res_valid, 1);
      checkOutput("lat_e2_res_y", res_y, 7);
      checkOutput("lat_e2_res_zero", res_zero, 0);
      waitDrain(20);

      // Back-to-back SUB then XOR: results two cycles apart.
      applyStimulus(1, 4'd2, 4'd5, OP_SUB);
      nextCycle();
      applyStimulus(1, 4'd9, 4'd9, OP_XOR);
      nextCycle();
      applyStimulus(0, 0, 0, 0);
      waitDrain(20);
      checkOutput("b2b_gap", lastGap, 2);

      // Backpressure: one held result plus four queued fills the sequencer.
      res_ready = 1'b0;
      base = accepted;
      applyStimulus(1, 4'($urandom), 4'($urandom), 3'($urandom_range(0, 4)));
      n = 0;
      while (cmd_ready && n < 20) begin
         nextCycle();
         applyStimulus(1, 4'($urandom), 4'($urandom), 3'($urandom_range(0, 4)));
         n++;
      end
      applyStimulus(0, 0, 0, 0);
      checkOutput("fill_accepted", accepted - base, 5);
      repeat (3) nextCycle();
      checkOutput("fill_ready_low", cmd_ready, 0);
      checkOutput("fill_res_valid", res_valid, 1);
      waitDrain(40);
      checkOutput("fill_ready_back", cmd_ready, 1);

      // Illegal opcode 110 with F,F.
      cntBefore = issue_cnt;
      applyStimulus(1, 4'hF, 4'hF, 3'b110);
      nextCycle();
      applyStimulus(0, 0, 0, 0);
      repeat (2) nextCycle();
      waitDrain(20);
`ifdef ALU_OP_CHECK_EN
      checkOutput("illegal_issue_cnt", issue_cnt, cntBefore);
`else
      checkOutput("illegal_issue_cnt", issue_cnt, 8'(cntBefore + 8'd1));
`endif

      // Reset while holding a result with three commands queued.
      res_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 4'($urandom), 4'($urandom), 3'($urandom_range(0, 4)));
         nextCycle();
      end
      applyStimulus(0, 0, 0, 0);
      nextCycle();
      checkOutput("pre_reset_hold", res_valid, 1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkResetValues("async_reset");
      nextCycle();
      rst_n = 1'b1;
      res_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         nextCycle();
         checkOutput("post_reset_valid", res_valid, 0);
      end

      // Randomized traffic against the reference queue.
      for (int i = 0; i < 300; i++) begin
         applyStimulus($urandom_range(0, 9) < 7, 4'($urandom), 4'($urandom), 3'($urandom_range(0, 7)));
         res_ready = ($urandom_range(0, 9) < 6);
         nextCycle();
      end
      applyStimulus(0, 0, 0, 0);
      waitDrain(100);
      checkOutput("random_issue_cnt", issue_cnt, 8'(accepted));

      // 256 issued commands wrap the issue counter back to zero.
      resetDut();
      res_ready = 1'b1;
      n = 0;
      while (accepted < 256 && n < 2000) begin
         applyStimulus(1, 4'($urandom), 4'($urandom), 3'($urandom_range(0, 4)));
         nextCycle();
         n++;
      end
      applyStimulus(0, 0, 0, 0);
      checkOutput("wrap_accepted", accepted, 256);
      waitDrain(50);
      checkOutput("wrap_issue_cnt", issue_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Upstream issue stage for the 4-bit combinational ALU. Accepts operand/opcode commands over a valid/ready interface and buffers them in a small FIFO. Issues one command at a time on registered ALU operand/select lines, captures the ALU result the following cycle, and presents it downstream with a valid/ready handshake plus a zero flag.

Parameters:
DATA_W, 4, operand/result width; matches the ALU datapath.
SEL_W, 3, opcode width; matches the ALU select.
DEPTH, 4, command FIFO entries; power of 2, minimum 2.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  FIFO can accept; equals !full.
cmd_a  input  DATA_W  operand A.
cmd_b  input  DATA_W  operand B.
cmd_sel  input  SEL_W  opcode (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR).
alu_a  output  DATA_W  registered operand A to the ALU.
alu_b  output  DATA_W  registered operand B to the ALU.
alu_sel  output  SEL_W  registered select to the ALU.
alu_y  input  DATA_W  combinational ALU result.
res_valid  output  1  result available.
res_ready  input  1  downstream accepts result.
res_y  output  DATA_W  captured result.
res_sel  output  SEL_W  opcode that produced res_y.
res_zero  output  1  res_y == 0.
issue_cnt  output  8  count of commands issued; wraps 255 -> 0.

Behaviour:
- Reset (async assert, sync release): FIFO empty; state IDLE; alu_a/alu_b/alu_sel = 0; res_valid = 0; res_y/res_sel = 0; res_zero = 1; issue_cnt = 0. A reset mid-operation discards all queued and in-flight commands.
- Push on cmd_valid && cmd_ready. A full FIFO does not accept, even when a pop occurs in the same cycle.
- Pop decision uses the pre-edge empty flag. A push into an empty FIFO cannot be popped in the same cycle.
- FSM:
  - IDLE: if FIFO is non-empty, pop the head, load alu_a/b/sel, increment issue_cnt, go to ISSUE.
  - ISSUE: alu_y is valid this cycle. At the edge, capture res_y <= alu_y, res_sel <= alu_sel, res_zero <= (alu_y == 0), set res_valid = 1, go to HOLD.
  - HOLD: hold res_* stable while res_valid && !res_ready. On res_ready:
    - FIFO non-empty: clear res_valid, pop, load ALU regs, increment issue_cnt, go to ISSUE.
    - FIFO empty: clear res_valid, go to IDLE.
- Latency: command accepted at edge E0; res_valid is high after E2 at the earliest.
- Throughput: at most one result per 2 cycles, with res_ready held high.
- alu_a/b/sel hold their last issued values when not issuing.
- Opcodes 101..111 are passed through unmodified. The ALU returns 0, so res_zero = 1.
- Results are delivered in command order. No command is dropped except by reset or the optional check below.

Optional Feature:
ALU_OP_CHECK_EN:
- Defined: adds output cmd_err (1 bit, reset 0). A handshaken command with cmd_sel > 3'b100 is not enqueued; cmd_err pulses high for exactly one cycle after that edge. cmd_ready is unaffected.
- Undefined: no cmd_err port; all opcodes are enqueued.

Decomposition:
- Package alu_pkg: DATA_W/SEL_W defaults, opcode constants OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LAST_LEGAL, and the FSM state enum (IDLE, ISSUE, HOLD).
- Sub-module alu_cmd_fifo: synchronous FIFO storing {a, b, sel}, DEPTH entries, full/empty from wrap-bit pointers.

Test Plan:
- Reset release, push A=3 B=4 sel=000, res_ready=1 -> res_valid after E2 with res_y=7, res_sel=000, res_zero=0; issue_cnt=1.
- Push SUB 2-5, then XOR 9^9 back-to-back, res_ready=1 -> res_y=13 then res_y=0 with res_zero=1, in order, 2 cycles apart.
- Hold res_ready=0, push 5 commands -> cmd_ready drops after the 4th queued entry beyond the held result; res_* stable. Release res_ready -> all remaining results drain in order.
- sel=110 with A=F B=F -> res_y=0, res_zero=1. With ALU_OP_CHECK_EN: no result and a one-cycle cmd_err pulse.
- Assert rst_n low while in HOLD with 3 queued -> all outputs return to reset values immediately, cmd_ready=1, no stale result after release.
- 256 issued commands -> issue_cnt wraps to 0.
